// File: rtl/mk14_pkg.sv
// Shared constants and types for the MK14 keyboard matrix scanner.
package mk14_pkg;

    localparam int unsigned KBD_COLS = 8;
    localparam int unsigned KBD_ROWS = 8;

    typedef enum logic [1:0] {DRIVE, SAMPLE, EMIT} kbd_scan_state_t;

    // Active-low one-hot column drive pattern.
    function automatic logic [KBD_COLS-1:0] col_drive_n(input logic [2:0] col);
        return ~(8'h01 << col);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all ones (idle).
module sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mk14_kbd_scan.sv
// 8x8 active-low key matrix scanner with per-key debounce; emits one-cycle press/release events.
module mk14_kbd_scan
    import mk14_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_MHZ = 50,
    parameter int unsigned SETTLE_US      = 20,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  col_n,
    input  logic [7:0]  row_n,
    output logic        kbd_write_en,
    output logic [15:0] kbd_addr,
    output logic [2:0]  kbd_bit,
    output logic        kbd_pressed
);

    localparam int unsigned SettleCycles = CLOCK_FREQ_MHZ * SETTLE_US;
    localparam int unsigned SettleW      = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int unsigned CntW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned NumKeys      = KBD_COLS * KBD_ROWS;

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
    localparam logic [CntW-1:0]    CntLast    = CntW'(DEBOUNCE_SCANS - 1);

    kbd_scan_state_t state_q, state_d;

    logic [SettleW-1:0]            settle_q, settle_d;
    logic [2:0]                    col_q, col_d;
    logic [2:0]                    bit_q, bit_d;
    logic [KBD_ROWS-1:0]           sample_q, sample_d;
    logic [NumKeys-1:0]            stable_q, stable_d;
    logic [NumKeys-1:0][CntW-1:0]  cnt_q, cnt_d;
    logic [KBD_COLS-1:0]           col_n_q, col_n_d;
    logic                          we_q, we_d;
    logic [2:0]                    addr_q, addr_d;
    logic [2:0]                    ev_bit_q, ev_bit_d;
    logic                          pressed_q, pressed_d;

    logic [KBD_ROWS-1:0] row_sync;
    logic [5:0]          key_idx;
    logic                raw;

    sync_2ff #(
        .WIDTH (KBD_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_n),
        .q_o   (row_sync)
    );

    assign key_idx = {col_q, bit_q};
    assign raw     = ~sample_q[bit_q];

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        col_d     = col_q;
        bit_d     = bit_q;
        sample_d  = sample_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        ev_bit_d  = ev_bit_q;
        pressed_d = pressed_q;

        unique case (state_q)
            DRIVE: begin
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                sample_d = row_sync;
                bit_d    = 3'd0;
                state_d  = EMIT;
            end
            EMIT: begin
                // A disagreeing sample must persist DEBOUNCE_SCANS visits before it sticks.
                if (raw == stable_q[key_idx]) begin
                    cnt_d[key_idx] = '0;
                end else if (cnt_q[key_idx] == CntLast) begin
                    stable_d[key_idx] = raw;
                    cnt_d[key_idx]    = '0;
                    we_d              = 1'b1;
                    addr_d            = col_q;
                    ev_bit_d          = bit_q;
                    pressed_d         = raw;
                end else begin
                    cnt_d[key_idx] = cnt_q[key_idx] + 1'b1;
                end

                if (bit_q == 3'd7) begin
                    col_d   = col_q + 1'b1;
                    state_d = DRIVE;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = DRIVE;
        endcase

        // col_d only moves when entering DRIVE, so the drive is stable through SAMPLE/EMIT.
        col_n_d = col_drive_n(col_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DRIVE;
            settle_q  <= '0;
            col_q     <= 3'd0;
            bit_q     <= 3'd0;
            sample_q  <= '1;
            stable_q  <= '0;
            cnt_q     <= '0;
            col_n_q   <= '1;
            we_q      <= 1'b0;
            addr_q    <= 3'd0;
            ev_bit_q  <= 3'd0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            col_q     <= col_d;
            bit_q     <= bit_d;
            sample_q  <= sample_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            col_n_q   <= col_n_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            ev_bit_q  <= ev_bit_d;
            pressed_q <= pressed_d;
        end
    end

    assign col_n        = col_n_q;
    assign kbd_write_en = we_q;
    assign kbd_addr     = {13'd0, addr_q};
    assign kbd_bit      = ev_bit_q;
    assign kbd_pressed  = pressed_q;

endmodule

// File: tb/tb_mk14_kbd_scan.sv
// Directed bench for mk14_kbd_scan: 13-cycle column, 104-cycle frame, 3-scan debounce.
module tb_mk14_kbd_scan;

    logic        clk;
    logic        rst_n;
    logic [7:0]  col_n;
    logic [7:0]  row_n;
    logic        kbd_write_en;
    logic [15:0] kbd_addr;
    logic [2:0]  kbd_bit;
    logic        kbd_pressed;

    logic [63:0] keys;
    logic [7:0]  kbd_mem [8];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int          stamp;
        logic [15:0] addr;
        logic [2:0]  bt;
        logic        pressed;
    } ev_t;
    ev_t ev_q[$];

    mk14_kbd_scan #(
        .CLOCK_FREQ_MHZ (1),
        .SETTLE_US      (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col_n        (col_n),
        .row_n        (row_n),
        .kbd_write_en (kbd_write_en),
        .kbd_addr     (kbd_addr),
        .kbd_bit      (kbd_bit),
        .kbd_pressed  (kbd_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            if (!col_n[c]) row_n = row_n & ~keys[c*8 +: 8];
        end
    end

    // Event log plus a minimal MMU-side keyboard byte array (1 = released).
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) kbd_mem[i] <= 8'hFF;
        end else if (kbd_write_en === 1'b1) begin
            ev_q.push_back('{stamp: cyc, addr: kbd_addr, bt: kbd_bit, pressed: kbd_pressed});
            kbd_mem[kbd_addr[2:0]][kbd_bit] <= ~kbd_pressed;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] colv(input int c);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << c);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_col(input logic [7:0] v, output int stamp);
        int n;
        n = 0;
        while (col_n !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", 32'(col_n), 32'(v));
        stamp = cyc;
    endtask

    task automatic check_ev(input string tag, input int i, input int stamp,
                            input int addr, input int bt, input logic pr);
        if (ev_q.size() > i) begin
            check({tag, "_stamp"}, ev_q[i].stamp, stamp);
            check({tag, "_addr"}, 32'(ev_q[i].addr), addr);
            check({tag, "_bit"}, 32'(ev_q[i].bt), bt);
            check({tag, "_pressed"}, 32'(ev_q[i].pressed), 32'(pr));
        end else begin
            check({tag, "_present"}, ev_q.size(), i + 1);
        end
    endtask

    initial begin
        int p;
        int e;
        int r;
        int t;

        rst_n = 1'b0;
        keys  = '0;
        step(3);
        check("rst_col_n", 32'(col_n), 32'hFF);
        check("rst_we", 32'(kbd_write_en), 0);
        check("rst_addr", 32'(kbd_addr), 0);
        check("rst_bit", 32'(kbd_bit), 0);
        check("rst_pressed", 32'(kbd_pressed), 0);

        // Column sequence after reset release.
        rst_n = 1'b1;
        p = 0;
        step(1);
        p = 1;
        check("first_col", 32'(col_n), 32'hFE);
        for (int k = 1; k <= 8; k++) begin
            step(13 * k - 1 - p);
            check("col_hold", 32'(col_n), 32'(colv(k - 1)));
            step(1);
            check("col_next", 32'(col_n), 32'(colv(k % 8)));
            p = 13 * k;
        end
        step(1040 - p);
        check("idle_no_events", ev_q.size(), 0);

        // Single key col 2 row 5: press then release.
        wait_col(8'hFD, t);
        wait_col(8'hFE, e);
        ev_q.delete();
        keys[2*8+5] = 1'b1;
        step(246);
        check("c2r5_press_count", ev_q.size(), 1);
        check_ev("c2r5_press", 0, e + 245, 2, 5, 1'b1);
        keys[2*8+5] = 1'b0;
        step(314);
        check("c2r5_total_count", ev_q.size(), 2);
        check_ev("c2r5_release", 1, e + 557, 2, 5, 1'b0);

        // Bouncing key col 0 row 0: two frames pressed, one released.
        wait_col(8'hFD, t);
        wait_col(8'hFE, e);
        ev_q.delete();
        for (int i = 0; i < 3; i++) begin
            keys[0] = 1'b1;
            step(208);
            keys[0] = 1'b0;
            step(104);
        end
        check("bounce_no_events", ev_q.size(), 0);

        // Three keys in column 4 change together.
        wait_col(8'hFD, t);
        wait_col(8'hFE, e);
        ev_q.delete();
        keys[4*8+1] = 1'b1;
        keys[4*8+3] = 1'b1;
        keys[4*8+6] = 1'b1;
        step(273);
        check("multi_press_count", ev_q.size(), 3);
        check_ev("multi_p1", 0, e + 267, 4, 1, 1'b1);
        check_ev("multi_p3", 1, e + 269, 4, 3, 1'b1);
        check_ev("multi_p6", 2, e + 272, 4, 6, 1'b1);
        keys[4*8+1] = 1'b0;
        keys[4*8+3] = 1'b0;
        keys[4*8+6] = 1'b0;
        step(328);
        check("multi_total_count", ev_q.size(), 6);
        check_ev("multi_r1", 3, e + 579, 4, 1, 1'b0);
        check_ev("multi_r3", 4, e + 581, 4, 3, 1'b0);
        check_ev("multi_r6", 5, e + 584, 4, 6, 1'b0);

        // MMU-side view of column 3 (address 0xD03).
        keys[3*8+7] = 1'b1;
        step(420);
        check("mmu_d03_pressed", 32'(kbd_mem[3]), 32'h7F);
        keys[3*8+7] = 1'b0;
        step(420);
        check("mmu_d03_released", 32'(kbd_mem[3]), 32'hFF);

        // Reset during EMIT of column 1 with col 1 row 0 held.
        keys[1*8+0] = 1'b1;
        step(420);
        wait_col(8'hFE, t);
        wait_col(8'hFD, e);
        step(7);
        rst_n = 1'b0;
        #1;
        check("midrst_col_n", 32'(col_n), 32'hFF);
        check("midrst_we", 32'(kbd_write_en), 0);
        ev_q.delete();
        step(3);
        rst_n = 1'b1;
        r = cyc;
        step(228);
        check("postrst_count", ev_q.size(), 1);
        check_ev("postrst_press", 0, r + 227, 1, 0, 1'b1);
        step(400);
        check("postrst_no_release", ev_q.size(), 1);
        keys[1*8+0] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
